// File: rtl/calendar_set_ctrl.sv
// ---------------------------------------------------------------------------
// calendar_set_ctrl
// Mode/sequencing controller for the clock-calendar counter chain.
//  * Generates the 100 Hz time-base tick (only while running).
//  * Runs the user set-mode FSM: select a field, issue single-cycle increment
//    pulses with auto-repeat, blink the selected field, and fall back to RUN
//    after an inactivity timeout.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   btn_mode    in   mode button level (synchronized, debounced)
//   btn_next    in   next-field button level
//   btn_inc     in   increment button level
//   tick_100hz  out  1-cycle pulse every TICK_DIV clks, only in RUN
//   run         out  1 in RUN (counter chain enable)
//   inc_hour/inc_min/inc_day/inc_month/inc_year
//               out  1-cycle increment pulses for the selected field
//   field_sel   out  0=RUN 1=HOUR 2=MIN 3=DAY 4=MONTH 5=YEAR
//   blink       out  display-visible flag for the selected field
//   clr_sec     out  clear-seconds pulse on SET->RUN
//
// Optional feature macro: SET_CLEAR_SECONDS_EN
//   defined   -> clr_sec pulses for one cycle with every SET->RUN transition
//   undefined -> clr_sec is constant 0
// ---------------------------------------------------------------------------
module calendar_set_ctrl #(
    parameter int TICK_DIV    = 500000,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10,
    parameter int BLINK_HALF  = 25,
    parameter int TIMEOUT     = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic       tick_100hz,
    output logic       run,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_day,
    output logic       inc_month,
    output logic       inc_year,
    output logic [2:0] field_sel,
    output logic       blink,
    output logic       clr_sec
);

    localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int PRE_W   = $clog2(TICK_DIV + 1);
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_HALF + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_DAY   = 3'd3,
        SET_MONTH = 3'd4,
        SET_YEAR  = 3'd5
    } stateT;

    stateT             state;
    stateT             nextState;
    logic              btnModeQ;
    logic              btnNextQ;
    logic              btnIncQ;
    logic [PRE_W-1:0]  preCnt;
    logic [REP_W-1:0]  repCnt;
    logic              repPhase;   // 0: waiting for first repeat, 1: repeating
    logic [BLK_W-1:0]  blinkCnt;
    logic [TO_W-1:0]   toCnt;

    logic edgeMode;
    logic edgeNext;
    logic edgeInc;
    logic anyEdge;
    logic inSet;
    logic wrap;
    logic holdInc;
    logic repFire;
    logic timeoutHit;
    logic incFire;

    // Edge detection, tick, auto-repeat/timeout decisions and next-state logic
    always_comb begin
        edgeMode = btn_mode & ~btnModeQ;
        edgeNext = btn_next & ~btnNextQ;
        edgeInc  = btn_inc & ~btnIncQ;
        anyEdge  = edgeMode | edgeNext | edgeInc;
        inSet    = (state != RUN);
        wrap     = (preCnt == PRE_W'(TICK_DIV - 1));

        // Auto-repeat only runs while the button is held past its edge cycle
        // and no higher-priority edge is moving the FSM this cycle.
        holdInc = inSet & btn_inc & btnIncQ & ~edgeMode & ~edgeNext;

        if (holdInc && wrap) begin
            if (!repPhase) begin
                repFire = (repCnt == REP_W'(REPEAT_DLY - 1));
            end else begin
                repFire = (repCnt == REP_W'(REPEAT_RATE - 1));
            end
        end else begin
            repFire = 1'b0;
        end

        timeoutHit = inSet & ~anyEdge & ~btn_inc & wrap & (toCnt == TO_W'(TIMEOUT - 1));
        incFire    = inSet & ~edgeMode & ~edgeNext & (edgeInc | repFire);

        nextState = state;
        case (state)
            RUN: begin
                if (edgeMode) begin
                    nextState = SET_HOUR;
                end else begin
                    nextState = RUN;
                end
            end
            SET_HOUR, SET_MIN, SET_DAY, SET_MONTH, SET_YEAR: begin
                if (edgeMode || (!edgeNext && timeoutHit)) begin
                    nextState = RUN;
                end else if (edgeNext) begin
                    case (state)
                        SET_HOUR:  nextState = SET_MIN;
                        SET_MIN:   nextState = SET_DAY;
                        SET_DAY:   nextState = SET_MONTH;
                        SET_MONTH: nextState = SET_YEAR;
                        default:   nextState = SET_HOUR;
                    endcase
                end else begin
                    nextState = state;
                end
            end
            default: nextState = RUN;
        endcase
    end

    // State, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            btnModeQ   <= 1'b0;
            btnNextQ   <= 1'b0;
            btnIncQ    <= 1'b0;
            preCnt     <= '0;
            repCnt     <= '0;
            repPhase   <= 1'b0;
            blinkCnt   <= '0;
            toCnt      <= '0;
            tick_100hz <= 1'b0;
            run        <= 1'b1;
            inc_hour   <= 1'b0;
            inc_min    <= 1'b0;
            inc_day    <= 1'b0;
            inc_month  <= 1'b0;
            inc_year   <= 1'b0;
            field_sel  <= 3'd0;
            blink      <= 1'b1;
            clr_sec    <= 1'b0;
        end else begin
            btnModeQ  <= btn_mode;
            btnNextQ  <= btn_next;
            btnIncQ   <= btn_inc;
            state     <= nextState;
            run       <= (nextState == RUN);
            field_sel <= nextState;

            // Restart the time base on re-entering RUN so the first tick
            // arrives a full period later.
            if (inSet && (nextState == RUN)) begin
                preCnt <= '0;
            end else if (wrap) begin
                preCnt <= '0;
            end else begin
                preCnt <= preCnt + PRE_W'(1);
            end
            tick_100hz <= wrap & ~inSet & (nextState == RUN);

            inc_hour  <= incFire & (state == SET_HOUR);
            inc_min   <= incFire & (state == SET_MIN);
            inc_day   <= incFire & (state == SET_DAY);
            inc_month <= incFire & (state == SET_MONTH);
            inc_year  <= incFire & (state == SET_YEAR);

            if (!holdInc) begin
                repCnt   <= '0;
                repPhase <= 1'b0;
            end else if (repFire) begin
                repCnt   <= '0;
                repPhase <= 1'b1;
            end else if (wrap) begin
                repCnt <= repCnt + REP_W'(1);
            end else begin
                repCnt <= repCnt;
            end

            // Blink restarts visible whenever the user does something.
            if (!inSet || (nextState == RUN) || edgeNext || incFire) begin
                blinkCnt <= '0;
                blink    <= 1'b1;
            end else if (wrap) begin
                if (blinkCnt == BLK_W'(BLINK_HALF - 1)) begin
                    blinkCnt <= '0;
                    blink    <= ~blink;
                end else begin
                    blinkCnt <= blinkCnt + BLK_W'(1);
                end
            end else begin
                blinkCnt <= blinkCnt;
            end

            if (!inSet || anyEdge || btn_inc || (nextState == RUN)) begin
                toCnt <= '0;
            end else if (wrap) begin
                toCnt <= toCnt + TO_W'(1);
            end else begin
                toCnt <= toCnt;
            end

`ifdef SET_CLEAR_SECONDS_EN
            clr_sec <= inSet & (nextState == RUN);
`else
            clr_sec <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calendar_set_ctrl
// Self-checking bench: a behavioural model (tick phase, held-tick counts,
// idle-tick counts) predicts every output each cycle; directed scenarios add
// hand-computed literal expectations, followed by randomized button traffic.
// ---------------------------------------------------------------------------
module tb_calendar_set_ctrl;

    localparam int TD = 4;
    localparam int RD = 3;
    localparam int RR = 2;
    localparam int BH = 2;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_inc = 1'b0;
    logic       tick_100hz;
    logic       run;
    logic       inc_hour;
    logic       inc_min;
    logic       inc_day;
    logic       inc_month;
    logic       inc_year;
    logic [2:0] field_sel;
    logic       blink;
    logic       clr_sec;

    calendar_set_ctrl #(
        .TICK_DIV(TD), .REPEAT_DLY(RD), .REPEAT_RATE(RR), .BLINK_HALF(BH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .tick_100hz(tick_100hz), .run(run), .inc_hour(inc_hour), .inc_min(inc_min),
        .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year),
        .field_sel(field_sel), .blink(blink), .clr_sec(clr_sec)
    );

    always #5 clk = ~clk;

    int nCmp  = 0;
    int nFail = 0;
    int nPrinted = 0;

    // Behavioural model state: field number, clocks since time-base start,
    // ticks held, ticks since blink restart, idle ticks, expected outputs.
    typedef struct packed {
        int       field;
        int       phase;
        int       held;
        int       blinkTicks;
        int       idle;
        bit       pm;
        bit       pn;
        bit       pi;
        bit       run;
        bit       tick;
        bit       blink;
        bit       clr;
        bit [4:0] inc;     // bit0 hour, 1 min, 2 day, 3 month, 4 year
    } modelT;

    modelT m = '{field: 0, phase: 0, held: 0, blinkTicks: 0, idle: 0, pm: 1'b0, pn: 1'b0,
                 pi: 1'b0, run: 1'b1, tick: 1'b0, blink: 1'b1, clr: 1'b0, inc: 5'd0};

    function automatic modelT modelStep(modelT s, bit r, bit bm, bit bn, bit bi);
        modelT n;
        bit em, en, ei, tick, inSet, fire;
        int nf;
        n = s;
        if (r) begin
            n = '{field: 0, phase: 0, held: 0, blinkTicks: 0, idle: 0, pm: 1'b0, pn: 1'b0,
                  pi: 1'b0, run: 1'b1, tick: 1'b0, blink: 1'b1, clr: 1'b0, inc: 5'd0};
            return n;
        end
        em    = bm && !s.pm;
        en    = bn && !s.pn;
        ei    = bi && !s.pi;
        tick  = (s.phase % TD) == (TD - 1);
        inSet = (s.field != 0);
        nf    = s.field;
        fire  = 1'b0;
        if (!inSet) begin
            if (em) nf = 1;
        end else if (em) begin
            nf = 0;
        end else if (en) begin
            nf = (s.field == 5) ? 1 : s.field + 1;
        end else if (ei) begin
            fire = 1'b1;
        end
        // auto-repeat: pulse on held tick RD, then every RR ticks
        if (inSet && bi && s.pi && !em && !en) begin
            if (tick) begin
                n.held = s.held + 1;
                if (n.held == RD || (n.held > RD && ((n.held - RD) % RR) == 0)) fire = 1'b1;
            end
        end else begin
            n.held = 0;
        end
        if (!inSet || em || en || ei || bi) begin
            n.idle = 0;
        end else if (tick) begin
            n.idle = s.idle + 1;
            if (n.idle >= TO) begin
                nf = 0;
                n.idle = 0;
            end
        end
        n.inc = fire ? 5'(1 << (s.field - 1)) : 5'd0;
        if (!inSet || nf == 0 || en || fire) begin
            n.blinkTicks = 0;
            n.blink = 1'b1;
        end else if (tick) begin
            n.blinkTicks = s.blinkTicks + 1;
            n.blink = ((n.blinkTicks / BH) % 2) == 0;
        end
        n.tick = !inSet && nf == 0 && tick;
`ifdef SET_CLEAR_SECONDS_EN
        n.clr = inSet && nf == 0;
`else
        n.clr = 1'b0;
`endif
        n.phase = (inSet && nf == 0) ? 0 : s.phase + 1;
        n.run   = (nf == 0);
        n.field = nf;
        n.pm    = bm;
        n.pn    = bn;
        n.pi    = bi;
        return n;
    endfunction

    // Advance the reference model on each active edge
    always @(posedge clk) m <= modelStep(m, rst, btn_mode, btn_next, btn_inc);

    int tickSeen = 0;
    int mTickSeen = 0;
    int incSeen [5] = '{0, 0, 0, 0, 0};
    int mIncSeen [5] = '{0, 0, 0, 0, 0};

    // Per-cycle compare of every output against the model, plus pulse counters
    always @(negedge clk) begin
        logic [12:0] dv;
        logic [12:0] ev;
        dv = {run, field_sel, tick_100hz, inc_year, inc_month, inc_day, inc_min, inc_hour, blink, clr_sec, 1'b0};
        ev = {m.run, 3'(m.field), m.tick, m.inc, m.blink, m.clr, 1'b0};
        nCmp++;
        if (dv !== ev) begin
            nFail++;
            if (nPrinted < 30) begin
                nPrinted++;
                $display("FAIL cycle t=%0t: actual run=%b fs=%0d tick=%b inc=%b blink=%b clr=%b; required run=%b fs=%0d tick=%b inc=%b blink=%b clr=%b",
                         $time, run, field_sel, tick_100hz, {inc_year, inc_month, inc_day, inc_min, inc_hour}, blink, clr_sec,
                         m.run, m.field, m.tick, m.inc, m.blink, m.clr);
            end
        end
        tickSeen  += int'(tick_100hz);
        mTickSeen += int'(m.tick);
        incSeen[0] += int'(inc_hour);
        incSeen[1] += int'(inc_min);
        incSeen[2] += int'(inc_day);
        incSeen[3] += int'(inc_month);
        incSeen[4] += int'(inc_year);
        for (int k = 0; k < 5; k++) mIncSeen[k] += int'(m.inc[k]);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Literal expectation checked against both DUT and model
    task automatic lit(input string nm, input int dutV, input int modV, input int expV);
        nCmp += 2;
        if (dutV != expV) begin
            nFail++;
            $display("FAIL %s: actual %0d, required %0d", nm, dutV, expV);
        end
        if (modV != expV) begin
            nFail++;
            $display("FAIL %s(model): actual %0d, required %0d", nm, modV, expV);
        end
    endtask

    task automatic pressMode();
        btn_mode = 1'b1; step(1); btn_mode = 1'b0; step(1);
    endtask

    task automatic pressNext(input int n);
        repeat (n) begin
            btn_next = 1'b1; step(1); btn_next = 1'b0; step(1);
        end
    endtask

    function automatic int sumArr(input int a [5]);
        return a[0] + a[1] + a[2] + a[3] + a[4];
    endfunction

    initial begin
        int t0, mt0, s0, ms0, a, ma, n, prob;
        bit clrExp;
`ifdef SET_CLEAR_SECONDS_EN
        clrExp = 1'b1;
`else
        clrExp = 1'b0;
`endif
        rst = 1'b1;
        step(3);
        lit("reset run", int'(run), int'(m.run), 1);
        lit("reset field_sel", int'(field_sel), m.field, 0);
        lit("reset blink", int'(blink), int'(m.blink), 1);
        rst = 1'b0;

        // idle in RUN: a tick every 4th clk, no increments
        t0 = tickSeen; mt0 = mTickSeen; s0 = sumArr(incSeen); ms0 = sumArr(mIncSeen);
        step(40);
        lit("idle ticks", tickSeen - t0, mTickSeen - mt0, 10);
        lit("idle inc", sumArr(incSeen) - s0, sumArr(mIncSeen) - ms0, 0);

        // enter SET_HOUR
        btn_mode = 1'b1; step(1);
        lit("enter run", int'(run), int'(m.run), 0);
        lit("enter field", int'(field_sel), m.field, 1);
        lit("enter tick", int'(tick_100hz), int'(m.tick), 0);
        btn_mode = 1'b0; step(1);
        pressNext(2);
        lit("field day", int'(field_sel), m.field, 3);

        // single increment tap
        a = incSeen[2]; ma = mIncSeen[2];
        btn_inc = 1'b1; step(1);
        lit("inc_day pulse", int'(inc_day), int'(m.inc[2]), 1);
        btn_inc = 1'b0; step(5);
        lit("inc_day count", incSeen[2] - a, mIncSeen[2] - ma, 1);

        // auto-repeat in SET_MIN: edge + held ticks 3, 5, 7
        pressNext(4);
        lit("field min", int'(field_sel), m.field, 2);
        a = incSeen[1]; ma = mIncSeen[1];
        btn_inc = 1'b1; step(30);
        lit("repeat count", incSeen[1] - a, mIncSeen[1] - ma, 4);
        btn_inc = 1'b0; step(20);
        lit("after release", incSeen[1] - a, mIncSeen[1] - ma, 4);

        // next + inc together in SET_HOUR: next wins, no pulse
        pressNext(4);
        lit("field hour", int'(field_sel), m.field, 1);
        s0 = sumArr(incSeen); ms0 = sumArr(mIncSeen);
        btn_next = 1'b1; btn_inc = 1'b1; step(1);
        lit("next>inc field", int'(field_sel), m.field, 2);
        btn_next = 1'b0; btn_inc = 1'b0; step(5);
        lit("next>inc pulses", sumArr(incSeen) - s0, sumArr(mIncSeen) - ms0, 0);

        // mode + next together: mode wins
        btn_mode = 1'b1; btn_next = 1'b1; step(1);
        lit("mode>next field", int'(field_sel), m.field, 0);
        lit("mode>next run", int'(run), int'(m.run), 1);
        btn_mode = 1'b0; btn_next = 1'b0; step(2);

        // inactivity timeout from SET_YEAR
        pressMode();
        pressNext(4);
        lit("field year", int'(field_sel), m.field, 5);
        n = 0;
        while (run !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        nCmp++;
        if (n < 70 || n > 85) begin
            nFail++;
            $display("FAIL timeout latency: actual %0d clks, required 70..85", n);
        end
        lit("timeout clr_sec", int'(clr_sec), int'(m.clr), int'(clrExp));
        for (int i = 1; i <= 4; i++) begin
            step(1);
            lit("first tick", int'(tick_100hz), int'(m.tick), (i == 4) ? 1 : 0);
        end

        // reset during auto-repeat in SET_MONTH
        pressMode();
        pressNext(3);
        lit("field month", int'(field_sel), m.field, 4);
        btn_inc = 1'b1; step(16);
        rst = 1'b1; step(1);
        lit("rst run", int'(run), int'(m.run), 1);
        lit("rst field", int'(field_sel), m.field, 0);
        lit("rst inc_month", int'(inc_month), int'(m.inc[3]), 0);
        lit("rst blink", int'(blink), int'(m.blink), 1);
        rst = 1'b0;
        a = incSeen[3]; ma = mIncSeen[3];
        step(20);
        lit("post-rst inc_month", incSeen[3] - a, mIncSeen[3] - ma, 0);
        btn_inc = 1'b0; step(2);

        // randomized traffic with varying activity levels
        for (int seg = 0; seg < 15; seg++) begin
            case ($urandom_range(0, 2))
                0:       prob = 4;
                1:       prob = 30;
                default: prob = 300;
            endcase
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, prob - 1) == 0) btn_mode = ~btn_mode;
                if ($urandom_range(0, prob - 1) == 0) btn_next = ~btn_next;
                if ($urandom_range(0, prob / 2) == 0) btn_inc = ~btn_inc;
                rst = ($urandom_range(0, 999) == 0);
                step(1);
            end
        end
        rst = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/calendar_set_ctrl.md
Name: calendar_set_ctrl

Overview:
Mode/sequencing controller for the clock-calendar counter chain (hundredths → seconds → minutes → hours → day → month → year).
- Generates the 100 Hz time-base tick that drives the counter chain.
- Gates normal running via `run`.
- Runs a user set-mode FSM: buttons select a field and issue single-cycle increment pulses to the day, month, hour, minute and year counters, with auto-repeat, blink and inactivity timeout.
- Sits between the (already synchronized and debounced) button inputs and the counter chain.

Parameters:
- TICK_DIV, 500000, clk cycles per 100 Hz tick (50 MHz clk); minimum 2.
- REPEAT_DLY, 50, ticks btn_inc must be held before auto-repeat starts (0.5 s).
- REPEAT_RATE, 10, ticks between auto-repeat pulses (0.1 s).
- BLINK_HALF, 25, ticks per blink half-period.
- TIMEOUT, 3000, ticks without a button edge in a set state before forced return to RUN (30 s).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- btn_mode  in  1  mode button level (synchronized, debounced)
- btn_next  in  1  next-field button level
- btn_inc  in  1  increment button level
- tick_100hz  out  1  1-cycle pulse every TICK_DIV clks; only asserted in RUN
- run  out  1  1 in RUN state (counter chain enable)
- inc_hour  out  1  1-cycle increment pulse, hours
- inc_min  out  1  1-cycle increment pulse, minutes
- inc_day  out  1  1-cycle increment pulse, day
- inc_month  out  1  1-cycle increment pulse, month
- inc_year  out  1  1-cycle increment pulse, year (drives leap-year phase)
- field_sel  out  3  0=RUN, 1=HOUR, 2=MIN, 3=DAY, 4=MONTH, 5=YEAR
- blink  out  1  display-visible flag for the selected field
- clr_sec  out  1  see Optional Feature

Behaviour:
- All outputs are registered. Reset values:
  - state=RUN, run=1, field_sel=0, blink=1.
  - tick_100hz, all inc_*, and clr_sec = 0.
  - Prescaler, repeat counter, blink counter, timeout counter and button-history registers = 0.
- Edge detect: edge_x = btn_x & ~btn_x_q, where btn_x_q is the previous-cycle sample. Responses appear one clk after the cycle the edge is detected.
- Prescaler:
  - Counts 0..TICK_DIV-1 continuously and wraps; an internal tick fires on wrap.
  - tick_100hz = internal tick & (state==RUN).
  - Prescaler clears to 0 in the cycle the state enters RUN, so the first tick comes TICK_DIV clks later.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_DAY, SET_MONTH, SET_YEAR.
  - RUN, edge_mode → SET_HOUR.
  - Any SET state, edge_mode → RUN.
  - edge_next in a SET state → next field: HOUR→MIN→DAY→MONTH→YEAR→HOUR.
  - edge_next in RUN and edge_inc in RUN are ignored.
  - Timeout counter reaches TIMEOUT → RUN.
- Priority within one cycle: edge_mode > edge_next > edge_inc. A lower-priority edge in the same cycle is discarded; no pulse is issued.
- Increment:
  - edge_inc in a SET state → exactly one pulse on the selected field's inc_* output.
  - While btn_inc stays high, the repeat counter counts internal ticks. On reaching REPEAT_DLY it issues a pulse, then one pulse every REPEAT_RATE ticks.
  - Repeat counter clears when btn_inc goes low or the state changes.
  - At most one inc_* is high in any cycle; never in RUN.
- Counter-chain wrap (e.g. day rollover by month or leap year) is owned by the counters; this block only pulses.
- Blink:
  - In SET states, blink toggles every BLINK_HALF ticks.
  - Blink forces to 1 and its counter restarts on any edge_next or inc pulse.
  - blink = 1 in RUN.
- Timeout counter:
  - Counts ticks in SET states; clears on any button edge or while btn_inc is held.
  - Held at 0 in RUN.
- rst asserted mid-operation (e.g. during auto-repeat) → reset values on the next clk; no pulse is emitted in that cycle.

Optional Feature:
- Macro SET_CLEAR_SECONDS_EN.
- Defined: on every SET→RUN transition (edge_mode or timeout), clr_sec pulses 1 for one cycle, coincident with run rising. The counter chain zeroes hundredths and seconds.
- Undefined: clr_sec is constant 0 and seconds continue from their frozen value.

Test Plan:
Bench params: TICK_DIV=4, REPEAT_DLY=3, REPEAT_RATE=2, BLINK_HALF=2, TIMEOUT=20.
- Reset then idle 40 clks → run=1, field_sel=0, tick_100hz high every 4th clk, no inc_* pulses.
- btn_mode rise → next clk run=0, field_sel=1, tick_100hz stays 0. Two btn_next edges → field_sel=3. btn_inc tap → single inc_day pulse one clk after the edge.
- Hold btn_inc in SET_MIN for 30 clks → one inc_min on the edge, then repeats at ticks 3, 5, 7 (clks ≈12, 20, 28 after the edge). No pulse after release.
- Same-cycle edges on btn_next and btn_inc in SET_HOUR → field_sel=2, no inc_* pulse. Same-cycle edges on btn_mode and btn_next → RUN.
- Enter SET_YEAR, idle 20 ticks (80 clks) → returns to RUN, run=1, first tick_100hz 4 clks later. With SET_CLEAR_SECONDS_EN, clr_sec pulses once at the transition.
- Assert rst during auto-repeat in SET_MONTH → next clk all reset values; no inc_month after rst deasserts while btn_inc is still held, until a new edge.
